uc_multiciclo: RTL and testbench
================================

UC_MULTICICLO -- requirements
Module: uc_multiciclo

Interface
REQ-001 The block SHALL have parameter CNT_BITS, default 16, width of the retired-instruction counter.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port opcode, input, 7, instruction opcode from the datapath instruction register.
REQ-005 The block SHALL have port alu_flags, input, 4: bit0 zero, bit1 MSB, bit2 overflow, bit3 unused.
REQ-006 The block SHALL have ports d_mem_we and rf_we, output, 1 each: data-memory write strobe and register-file write strobe.
REQ-007 The block SHALL have port alu_cmd, output, 4, format class: R=0000, I=0001, S=0010, SB=0011, U=0100, UJ=0101.
REQ-008 The block SHALL have ports alu_src, pc_src and rf_src, output, 1 each: 0/1 = rf/imm, +4/+imm and alu/d_mem.
REQ-009 The block SHALL have port state, output, 3, current FSM state code.
REQ-010 The block SHALL have port retired, output, CNT_BITS, count of completed instructions.
REQ-011 The block SHALL have port halt, output, 1, sticky trap indicator (see Configuration).

Function
REQ-012 The FSM SHALL use states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and HALT=5, and SHALL advance at most one state per clk edge.
REQ-013 In DECODE the block SHALL latch opcode into an internal class register; every later state SHALL decode from that register only, so opcode changes after DECODE are ignored.
REQ-014 Opcode classes SHALL be: 0110011 R; 0010011 I-alu; 0000011 load (I); 0100011 S; 1100011 SB; 0110111 U; 1101111 UJ; all other opcodes are illegal.
REQ-015 Transitions SHALL be FETCH->DECODE->EXEC, then: R, I-alu, U and UJ go EXEC->WB->FETCH; load goes EXEC->MEM->WB->FETCH; S goes EXEC->MEM->FETCH; SB goes EXEC->FETCH.
REQ-016 Instruction latency SHALL be: R, I-alu, U, UJ and S 4 cycles; load 5 cycles; SB 3 cycles.
REQ-017 In FETCH and DECODE, alu_cmd SHALL be 0000 and every other control output SHALL be 0.
REQ-018 From EXEC to the last state of the instruction, alu_cmd SHALL hold the latched class code, with alu_src=1 for I-alu, load, S and U, and 0 otherwise.
REQ-019 rf_we SHALL be 1 for exactly one cycle, in WB; d_mem_we SHALL be 1 for exactly one cycle, in MEM, for S only; the two SHALL never both be 1.
REQ-020 rf_src SHALL be 1 in MEM and WB of a load, and 0 otherwise.
REQ-021 pc_src SHALL be 1 in EXEC of SB when alu_flags[0]=1, in EXEC through WB of UJ, and 0 otherwise.
REQ-022 retired SHALL increment by 1 on the edge leaving the final state of each legal instruction, and SHALL wrap from all-ones to 0.

Reset
REQ-023 When rst=1 at a clk edge, state SHALL become FETCH, retired SHALL become 0, halt SHALL become 0 and the class register SHALL become R, regardless of current state.
REQ-024 A reset asserted mid-instruction SHALL abort it: no further strobes and no retired increment for that instruction.
REQ-025 While rst is held high, all control outputs SHALL be 0 and alu_cmd SHALL be 0000.

Configuration
REQ-026 With macro UC_ILLEGAL_TRAP_EN defined, an illegal opcode latched in DECODE SHALL move the FSM to HALT, set halt=1, keep all strobes 0, and remain there until rst; retired SHALL not increment.
REQ-027 Without UC_ILLEGAL_TRAP_EN, an illegal opcode SHALL go DECODE->FETCH with no strobes and no retired increment, halt SHALL be tied to 0, and state 5 SHALL be unreachable.

Verification
REQ-028 Reset, then opcode=0110011: state 0,1,2,4,0; rf_we=1 only in cycle 4; alu_cmd=0000; retired=1.
REQ-029 Opcode=0000011: state 0,1,2,3,4,0; alu_cmd=0001; alu_src=1; rf_src=1 in cycles 4-5; rf_we in cycle 5 only.
REQ-030 Opcode=0100011: d_mem_we=1 in cycle 4 only; rf_we never 1; alu_cmd=0010.
REQ-031 Opcode=1100011 with alu_flags=0001, then again with 0000: pc_src=1 in EXEC for the first only; both take 3 cycles; retired=2.
REQ-032 Opcode=1111111: with UC_ILLEGAL_TRAP_EN, state=5 and halt=1 until rst; without it, state returns to 0 after DECODE and retired is unchanged.
REQ-033 Assert rst during MEM of a store: d_mem_we=0 on the next edge, state=0 and retired=0.

Source files
------------

// File: rtl/uc_multiciclo.sv
// ---------------------------------------------------------------------------
// uc_multiciclo -- multicycle control unit for a small RISC-V style datapath.
//
// Purpose
//   Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB and
//   produces the datapath control strobes for every cycle. The opcode is
//   classified once, in DECODE, into an internal class register. All later
//   states decode from that register, so the instruction register may change
//   freely after DECODE.
//
// Ports
//   clk        in   1         rising-edge clock
//   rst        in   1         synchronous active-high reset
//   opcode     in   7         opcode field of the datapath instruction register
//   alu_flags  in   4         bit0 zero, bit1 MSB, bit2 overflow, bit3 unused
//   d_mem_we   out  1         data-memory write strobe (MEM of a store only)
//   rf_we      out  1         register-file write strobe (WB only)
//   alu_cmd    out  4         format class: R=0 I=1 S=2 SB=3 U=4 UJ=5
//   alu_src    out  1         ALU operand B: 0 register file, 1 immediate
//   pc_src     out  1         next PC: 0 PC+4, 1 PC+imm
//   rf_src     out  1         register write-back data: 0 ALU, 1 data memory
//   state      out  3         current FSM state code
//   retired    out  CNT_BITS  completed-instruction count, wraps to 0
//   halt       out  1         sticky illegal-instruction trap indicator
//
// Parameters
//   CNT_BITS   width of the retired-instruction counter (default 16)
//
// Build option
//   UC_ILLEGAL_TRAP_EN  when defined, an illegal opcode sends the FSM to HALT
//                       and sets halt until the next reset. When undefined,
//                       an illegal opcode is dropped (DECODE -> FETCH), halt
//                       is tied to 0 and the HALT state is never entered.
//
// State sequences per class
//   R, I-alu, U, UJ : FETCH DECODE EXEC WB        (4 cycles)
//   load            : FETCH DECODE EXEC MEM WB    (5 cycles)
//   store (S)       : FETCH DECODE EXEC MEM       (4 cycles)
//   branch (SB)     : FETCH DECODE EXEC           (3 cycles)
//   illegal         : FETCH DECODE, then FETCH or HALT
// ---------------------------------------------------------------------------
module uc_multiciclo #(
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic [3:0]          alu_flags,
    output logic                d_mem_we,
    output logic                rf_we,
    output logic [3:0]          alu_cmd,
    output logic                alu_src,
    output logic                pc_src,
    output logic                rf_src,
    output logic [2:0]          state,
    output logic [CNT_BITS-1:0] retired,
    output logic                halt
);

    // -----------------------------------------------------------------------
    // FSM state codes
    // -----------------------------------------------------------------------
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    // -----------------------------------------------------------------------
    // Internal instruction classes. Loads and I-alu share the I format on
    // alu_cmd but take different paths through the FSM, so they get separate
    // codes here.
    // -----------------------------------------------------------------------
    localparam logic [2:0] CLS_R   = 3'd0;
    localparam logic [2:0] CLS_I   = 3'd1;
    localparam logic [2:0] CLS_LD  = 3'd2;
    localparam logic [2:0] CLS_S   = 3'd3;
    localparam logic [2:0] CLS_SB  = 3'd4;
    localparam logic [2:0] CLS_U   = 3'd5;
    localparam logic [2:0] CLS_UJ  = 3'd6;
    localparam logic [2:0] CLS_ILL = 3'd7;

    // alu_cmd format codes
    localparam logic [3:0] CMD_R  = 4'b0000;
    localparam logic [3:0] CMD_I  = 4'b0001;
    localparam logic [3:0] CMD_S  = 4'b0010;
    localparam logic [3:0] CMD_SB = 4'b0011;
    localparam logic [3:0] CMD_U  = 4'b0100;
    localparam logic [3:0] CMD_UJ = 4'b0101;

    // -----------------------------------------------------------------------
    // Decode helpers
    // -----------------------------------------------------------------------
    function automatic logic [2:0] classify(input logic [6:0] op);
        logic [2:0] cls;
        case (op)
            7'b0110011: cls = CLS_R;
            7'b0010011: cls = CLS_I;
            7'b0000011: cls = CLS_LD;
            7'b0100011: cls = CLS_S;
            7'b1100011: cls = CLS_SB;
            7'b0110111: cls = CLS_U;
            7'b1101111: cls = CLS_UJ;
            default:    cls = CLS_ILL;
        endcase
        return cls;
    endfunction

    function automatic logic [3:0] class_cmd(input logic [2:0] cls);
        logic [3:0] cmd;
        case (cls)
            CLS_R:   cmd = CMD_R;
            CLS_I:   cmd = CMD_I;
            CLS_LD:  cmd = CMD_I;
            CLS_S:   cmd = CMD_S;
            CLS_SB:  cmd = CMD_SB;
            CLS_U:   cmd = CMD_U;
            CLS_UJ:  cmd = CMD_UJ;
            default: cmd = CMD_R;
        endcase
        return cmd;
    endfunction

    // Classes whose second ALU operand is the immediate.
    function automatic logic class_imm(input logic [2:0] cls);
        return (cls == CLS_I) || (cls == CLS_LD) || (cls == CLS_S) ||
               (cls == CLS_U);
    endfunction

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [2:0]          state_q,   state_d;
    logic [2:0]          cls_q,     cls_d;
    logic [CNT_BITS-1:0] retired_q, retired_d;
    logic [2:0]          dec_cls;
    logic                retire;

    // Only the zero flag steers control; the other flags are carried for
    // the datapath's benefit and intentionally ignored here.
    logic                unused_flags;
    assign unused_flags = ^alu_flags[3:1];

    assign dec_cls = classify(opcode);

`ifdef UC_ILLEGAL_TRAP_EN
    logic halt_q, halt_d;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic. "retire" marks the edge that leaves the final state
    // of a legal instruction; the counter bumps on exactly that edge.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        retire    = 1'b0;
`ifdef UC_ILLEGAL_TRAP_EN
        halt_d    = halt_q;
`endif

        case (state_q)
            ST_FETCH: begin
                state_d = ST_DECODE;
            end

            ST_DECODE: begin
                cls_d = dec_cls;
                if (dec_cls == CLS_ILL) begin
`ifdef UC_ILLEGAL_TRAP_EN
                    state_d = ST_HALT;
                    halt_d  = 1'b1;
`else
                    state_d = ST_FETCH;
`endif
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                case (cls_q)
                    CLS_LD, CLS_S: state_d = ST_MEM;
                    CLS_SB: begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                    // An illegal class never reaches EXEC; recover quietly.
                    CLS_ILL:       state_d = ST_FETCH;
                    default:       state_d = ST_WB;
                endcase
            end

            ST_MEM: begin
                if (cls_q == CLS_LD) begin
                    state_d = ST_WB;
                end else begin
                    // Store completes in MEM.
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end

            ST_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end

            ST_HALT: begin
`ifdef UC_ILLEGAL_TRAP_EN
                // Parked until reset.
                state_d = ST_HALT;
`else
                state_d = ST_FETCH;
`endif
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        retired_d = retire ? (retired_q + CNT_BITS'(1)) : retired_q;
    end

    // -----------------------------------------------------------------------
    // State registers with synchronous reset. Reset aborts any instruction in
    // flight: the retire pulse for it is discarded along with the state.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_R;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            retired_q <= retired_d;
        end
    end

`ifdef UC_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Control outputs. Moore-style on (state, class) except pc_src in EXEC of
    // a branch, which follows the live zero flag. Everything is forced low
    // while rst is high so a reset landing mid-instruction cannot let a
    // strobe through in the cycle before the state register clears.
    // -----------------------------------------------------------------------
    always_comb begin
        d_mem_we = 1'b0;
        rf_we    = 1'b0;
        alu_cmd  = CMD_R;
        alu_src  = 1'b0;
        pc_src   = 1'b0;
        rf_src   = 1'b0;

        if (!rst && (cls_q != CLS_ILL)) begin
            case (state_q)
                ST_EXEC: begin
                    alu_cmd = class_cmd(cls_q);
                    alu_src = class_imm(cls_q);
                    pc_src  = ((cls_q == CLS_SB) && alu_flags[0]) ||
                              (cls_q == CLS_UJ);
                end

                ST_MEM: begin
                    alu_cmd  = class_cmd(cls_q);
                    alu_src  = class_imm(cls_q);
                    d_mem_we = (cls_q == CLS_S);
                    rf_src   = (cls_q == CLS_LD);
                end

                ST_WB: begin
                    alu_cmd = class_cmd(cls_q);
                    alu_src = class_imm(cls_q);
                    rf_we   = 1'b1;
                    rf_src  = (cls_q == CLS_LD);
                    pc_src  = (cls_q == CLS_UJ);
                end

                default: begin
                    // FETCH, DECODE and HALT drive nothing.
                end
            endcase
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

`ifdef UC_ILLEGAL_TRAP_EN
    assign halt = halt_q;
`else
    assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_uc_multiciclo -- directed self-checking bench for uc_multiciclo.
//
// Each cycle's outputs are packed into one 12-bit word:
//   {state[2:0], alu_cmd[3:0], alu_src, pc_src, rf_src, rf_we, d_mem_we}
// so a hand-computed expected word per cycle covers every control output.
// The counter is built 4 bits wide so wrap-around is reachable quickly.
// ---------------------------------------------------------------------------
module tb_uc_multiciclo;

    localparam int CNT_BITS = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [6:0]          opcode;
    logic [3:0]          alu_flags;
    logic                d_mem_we;
    logic                rf_we;
    logic [3:0]          alu_cmd;
    logic                alu_src;
    logic                pc_src;
    logic                rf_src;
    logic [2:0]          state;
    logic [CNT_BITS-1:0] retired;
    logic                halt;

    int checks   = 0;
    int failures = 0;

    logic [11:0]         obs_w [0:7];
    int                  obs_n;
    logic [11:0]         exp_q [$];
    logic [CNT_BITS-1:0] exp_retired;

    uc_multiciclo #(.CNT_BITS(CNT_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .alu_flags (alu_flags),
        .d_mem_we  (d_mem_we),
        .rf_we     (rf_we),
        .alu_cmd   (alu_cmd),
        .alu_src   (alu_src),
        .pc_src    (pc_src),
        .rf_src    (rf_src),
        .state     (state),
        .retired   (retired),
        .halt      (halt)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    function automatic logic [11:0] pack_obs();
        return {state, alu_cmd, alu_src, pc_src, rf_src, rf_we, d_mem_we};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_retired = '0;
    endtask

    // Starts at a sample point in FETCH. Records one word per cycle until the
    // FSM is back in FETCH (bounded at 8 cycles). The opcode is held through
    // DECODE and then replaced by op_late.
    task automatic drive_instr(input logic [6:0] op, input logic [6:0] op_late,
                               input logic [3:0] flags);
        opcode    = op;
        alu_flags = flags;
        obs_n     = 0;
        for (int k = 0; k < 8; k++) begin
            obs_w[k] = pack_obs();
            obs_n    = k + 1;
            step();
            if (k == 1) opcode = op_late;
            if (state == 3'd0) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst       = 1'b1;
        opcode    = 7'b0110011;
        alu_flags = 4'b0001;
        step();
        checks++;
        if (pack_obs() !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h", pack_obs(), 12'h000);
        end
        checks++;
        if (retired !== '0) begin
            failures++;
            $display("FAIL reset_retired: got %0d expected 0", retired);
        end
        checks++;
        if (halt !== 1'b0) begin
            failures++;
            $display("FAIL reset_halt: got %b expected 0", halt);
        end
        step();
        rst = 1'b0;
        exp_retired = '0;
    endtask

    task automatic test_formats();
        string       names [9] = '{"r", "i_alu", "load", "store", "sb_taken",
                                   "sb_not", "sb_other_flags", "u", "uj"};
        logic [6:0]  ops   [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                   7'b0100011, 7'b1100011, 7'b1100011,
                                   7'b1100011, 7'b0110111, 7'b1101111};
        logic [3:0]  flg   [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                   4'b0001, 4'b0000, 4'b1110, 4'b0000,
                                   4'b0001};
        int          lens  [9] = '{4, 4, 5, 4, 3, 3, 3, 4, 4};
        logic [59:0] wds   [9] = '{
            {12'h000, 12'h200, 12'h400, 12'h802, 12'h000},
            {12'h000, 12'h200, 12'h430, 12'h832, 12'h000},
            {12'h000, 12'h200, 12'h430, 12'h634, 12'h836},
            {12'h000, 12'h200, 12'h450, 12'h651, 12'h000},
            {12'h000, 12'h200, 12'h468, 12'h000, 12'h000},
            {12'h000, 12'h200, 12'h460, 12'h000, 12'h000},
            {12'h000, 12'h200, 12'h460, 12'h000, 12'h000},
            {12'h000, 12'h200, 12'h490, 12'h892, 12'h000},
            {12'h000, 12'h200, 12'h4A8, 12'h8AA, 12'h000}};
        for (int i = 0; i < 9; i++) begin
            drive_instr(ops[i], ops[i], flg[i]);
            exp_q.delete();
            for (int k = 0; k < lens[i]; k++) exp_q.push_back(wds[i][59-12*k -: 12]);
            checks++;
            if (obs_n !== lens[i]) begin
                failures++;
                $display("FAIL %s_latency: got %0d expected %0d", names[i], obs_n, lens[i]);
            end
            for (int k = 0; k < lens[i] && k < obs_n; k++) begin
                checks++;
                if (obs_w[k] !== exp_q[k]) begin
                    failures++;
                    $display("FAIL %s_cycle%0d: got %h expected %h",
                             names[i], k + 1, obs_w[k], exp_q[k]);
                end
            end
            exp_retired = exp_retired + 1'b1;
            checks++;
            if (retired !== exp_retired) begin
                failures++;
                $display("FAIL %s_retired: got %0d expected %0d", names[i], retired, exp_retired);
            end
        end
    endtask

    // The opcode changes right after DECODE; the latched class must win.
    task automatic test_opcode_change();
        logic [6:0]  ops  [2] = '{7'b0000011, 7'b0100011};
        logic [6:0]  late [2] = '{7'b0100011, 7'b1111111};
        int          lens [2] = '{5, 4};
        logic [59:0] wds  [2] = '{
            {12'h000, 12'h200, 12'h430, 12'h634, 12'h836},
            {12'h000, 12'h200, 12'h450, 12'h651, 12'h000}};
        for (int i = 0; i < 2; i++) begin
            drive_instr(ops[i], late[i], 4'b0000);
            checks++;
            if (obs_n !== lens[i]) begin
                failures++;
                $display("FAIL latch_latency%0d: got %0d expected %0d", i, obs_n, lens[i]);
            end
            for (int k = 0; k < lens[i] && k < obs_n; k++) begin
                checks++;
                if (obs_w[k] !== wds[i][59-12*k -: 12]) begin
                    failures++;
                    $display("FAIL latch%0d_cycle%0d: got %h expected %h",
                             i, k + 1, obs_w[k], wds[i][59-12*k -: 12]);
                end
            end
            exp_retired = exp_retired + 1'b1;
        end
        checks++;
        if (retired !== exp_retired) begin
            failures++;
            $display("FAIL latch_retired: got %0d expected %0d", retired, exp_retired);
        end
    endtask

    // R, SB, S with no idle cycles: 4 + 3 + 4 cycles and three retirements.
    task automatic test_back_to_back();
        int total;
        total = 0;
        drive_instr(7'b0110011, 7'b0110011, 4'b0000);
        total += obs_n;
        drive_instr(7'b1100011, 7'b1100011, 4'b0001);
        total += obs_n;
        drive_instr(7'b0100011, 7'b0100011, 4'b0000);
        total += obs_n;
        exp_retired = exp_retired + 4'd3;
        checks++;
        if (total !== 11) begin
            failures++;
            $display("FAIL b2b_cycles: got %0d expected 11", total);
        end
        checks++;
        if (retired !== exp_retired) begin
            failures++;
            $display("FAIL b2b_retired: got %0d expected %0d", retired, exp_retired);
        end
    endtask

    task automatic test_illegal();
`ifdef UC_ILLEGAL_TRAP_EN
        opcode    = 7'b1111111;
        alu_flags = 4'b0000;
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pack_obs() !== 12'hA00 || halt !== 1'b1) begin
                failures++;
                $display("FAIL trap_hold%0d: got %h halt %b expected %h halt 1",
                         k, pack_obs(), halt, 12'hA00);
            end
            step();
        end
        checks++;
        if (retired !== exp_retired) begin
            failures++;
            $display("FAIL trap_retired: got %0d expected %0d", retired, exp_retired);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_retired = '0;
        checks++;
        if (pack_obs() !== 12'h000 || halt !== 1'b0 || retired !== exp_retired) begin
            failures++;
            $display("FAIL trap_clear: got %h halt %b retired %0d expected 000 halt 0 retired 0",
                     pack_obs(), halt, retired);
        end
`else
        logic [6:0] ill [3] = '{7'b1111111, 7'b0000000, 7'b1110011};
        for (int i = 0; i < 3; i++) begin
            drive_instr(ill[i], ill[i], 4'b0001);
            checks++;
            if (obs_n !== 2 || obs_w[0] !== 12'h000 || obs_w[1] !== 12'h200) begin
                failures++;
                $display("FAIL illegal%0d_seq: got n=%0d %h %h expected n=2 000 200",
                         i, obs_n, obs_w[0], obs_w[1]);
            end
            checks++;
            if (retired !== exp_retired || halt !== 1'b0) begin
                failures++;
                $display("FAIL illegal%0d_state: got retired %0d halt %b expected %0d halt 0",
                         i, retired, halt, exp_retired);
            end
        end
`endif
    endtask

    // Reset lands while a store sits in MEM.
    task automatic test_reset_mid_store();
        opcode    = 7'b0100011;
        alu_flags = 4'b0000;
        step();
        step();
        step();
        checks++;
        if (pack_obs() !== 12'h651) begin
            failures++;
            $display("FAIL midrst_in_mem: got %h expected %h", pack_obs(), 12'h651);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (pack_obs() !== 12'h600) begin
            failures++;
            $display("FAIL midrst_gated: got %h expected %h", pack_obs(), 12'h600);
        end
        step();
        rst = 1'b0;
        exp_retired = '0;
        checks++;
        if (pack_obs() !== 12'h000 || retired !== exp_retired) begin
            failures++;
            $display("FAIL midrst_after: got %h retired %0d expected 000 retired 0",
                     pack_obs(), retired);
        end
        drive_instr(7'b0110011, 7'b0110011, 4'b0000);
        exp_retired = exp_retired + 1'b1;
        checks++;
        if (obs_n !== 4 || obs_w[3] !== 12'h802 || retired !== exp_retired) begin
            failures++;
            $display("FAIL midrst_recover: got n=%0d wb=%h retired %0d expected n=4 802 %0d",
                     obs_n, obs_w[3], retired, exp_retired);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive_instr(7'b1100011, 7'b1100011, 4'b0000);
            exp_retired = exp_retired + 1'b1;
        end
        checks++;
        if (retired !== 4'hF || retired !== exp_retired) begin
            failures++;
            $display("FAIL wrap_full: got %0d expected 15", retired);
        end
        drive_instr(7'b1100011, 7'b1100011, 4'b0000);
        exp_retired = exp_retired + 1'b1;
        checks++;
        if (retired !== 4'h0 || retired !== exp_retired) begin
            failures++;
            $display("FAIL wrap_zero: got %0d expected 0", retired);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst       = 1'b1;
        opcode    = 7'b0000000;
        alu_flags = 4'b0000;
        exp_retired = '0;
        test_reset();
        test_formats();
        test_opcode_change();
        test_back_to_back();
        test_illegal();
        test_reset_mid_store();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
